spi_burst_seq: RTL and testbench

SPI_BURST_SEQ -- requirements
Module: spi_burst_seq

---
 rtl/spi_burst_seq.sv | 125 ++++++++++++
 tb/tb_spi_burst_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_seq.sv
// spi_burst_seq: sequences a chip-select burst of up to MAX_BYTES bytes through an SPI master.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_wr_en, i_wr_addr, i_wr_data  TX buffer write port (accepted only while idle)
//   i_start, i_len                 burst request and length in bytes
//   i_rd_addr, o_rd_data           combinational RX buffer read port
//   o_busy, o_done, o_err          status: burst active, completion pulse, error pulse
//   o_TX_count, o_TX_Byte, o_TX_DV master side: byte count, byte, byte-valid strobe
//   i_TX_Ready, i_RX_DV, i_RX_Byte master side: ready, received byte strobe and data
//   i_SPI_CS_n                     chip select from the master, marks end of burst
// Define SPI_BURST_WATCHDOG_EN to add a TIMEOUT_CLKS watchdog on SEND/WAIT_RX.
module spi_burst_seq #(
    parameter int MAX_BYTES    = 4,
    parameter int TIMEOUT_CLKS = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [2:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_start,
    input  logic [2:0] i_len,
    input  logic [2:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [2:0] o_TX_count,
    output logic [7:0] o_TX_Byte,
    output logic       o_TX_DV,
    input  logic       i_TX_Ready,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_SPI_CS_n
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;
    localparam logic [3:0] MAX = 4'(MAX_BYTES);
    state_t     state, state_nxt;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [2:0] tx_idx, rx_idx;
    logic       len_ok, start_ok, start_bad, strobe, last_strobe, rx_take, timeout;

`ifdef SPI_BURST_WATCHDOG_EN
    logic [15:0] wd_cnt;
    assign timeout = (state == SEND || state == WAIT_RX) && wd_cnt == 16'(TIMEOUT_CLKS - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            wd_cnt <= '0;
        else if (state == IDLE)
            wd_cnt <= '0;
        else if (state == SEND || state == WAIT_RX)
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    // without the watchdog the limit has no role
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CLKS != 0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        len_ok      = i_len != 3'd0 && {1'b0, i_len} <= MAX;
        start_ok    = state == IDLE && i_start && len_ok;
        start_bad   = state == IDLE && i_start && !len_ok;
        // the !o_TX_DV term forces a gap cycle between strobes
        strobe      = state == SEND && i_TX_Ready && !o_TX_DV && !timeout;
        last_strobe = strobe && tx_idx + 3'd1 == o_TX_count;
        rx_take     = (state == SEND || state == WAIT_RX) && i_RX_DV && rx_idx < o_TX_count;
        o_busy      = state != IDLE;
        o_done      = state == DONE;
        state_nxt   = state;
        case (state)
            IDLE:    state_nxt = start_ok ? SEND : IDLE;
            SEND:    state_nxt = timeout ? IDLE : last_strobe ? WAIT_RX : SEND;
            WAIT_RX: state_nxt = timeout ? IDLE : (rx_idx == o_TX_count && i_SPI_CS_n) ? DONE : WAIT_RX;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                tx_buf[i] <= '0;
                rx_buf[i] <= '0;
            end
            tx_idx     <= '0;
            rx_idx     <= '0;
            o_TX_count <= '0;
            o_TX_Byte  <= '0;
            o_TX_DV    <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_TX_DV <= strobe;
            o_err   <= start_bad || timeout;
            if (state == IDLE && i_wr_en && {1'b0, i_wr_addr} < MAX)
                tx_buf[i_wr_addr] <= i_wr_data;
            if (start_ok) begin
                o_TX_count <= i_len;
                tx_idx     <= '0;
                rx_idx     <= '0;
            end
            // tracks tx_buf[tx_idx] one cycle behind, so the byte presented with
            // o_TX_DV is the one indexed at the strobing edge, before tx_idx advanced
            if (state == SEND)
                o_TX_Byte <= tx_buf[tx_idx];
            if (strobe)
                tx_idx <= tx_idx + 3'd1;
            if (rx_take) begin
                rx_buf[rx_idx] <= i_RX_Byte;
                rx_idx         <= rx_idx + 3'd1;
            end
        end
    end

    assign o_rd_data = {1'b0, i_rd_addr} < MAX ? rx_buf[i_rd_addr] : 8'h00;
endmodule

// File: tb/tb_spi_burst_seq.sv
// tb_spi_burst_seq: directed self-checking bench for spi_burst_seq with a simple SPI master model.
module tb_spi_burst_seq;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0, start = 1'b0, tx_ready = 1'b1, rx_dv = 1'b0, cs_n = 1'b1;
    logic [2:0] wr_addr = '0, len = '0, rd_addr = '0;
    logic [7:0] wr_data = '0, rx_byte = '0;
    logic [7:0] rd_data, tx_byte;
    logic [2:0] tx_count;
    logic       busy, done, err, tx_dv;
    logic [7:0] slave_rx [8];
    logic [7:0] exp_tx [8];
    logic [7:0] dv_log [64];
    int         dv_n = 0, done_n = 0, err_n = 0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_burst_seq #(.MAX_BYTES(4), .TIMEOUT_CLKS(20)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_start(start), .i_len(len), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy),
        .o_done(done), .o_err(err), .o_TX_count(tx_count), .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv),
        .i_TX_Ready(tx_ready), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_SPI_CS_n(cs_n)
    );

    always @(negedge clk) begin
        if (tx_dv) begin
            if (dv_n < 64) dv_log[dv_n] = tx_byte;
            dv_n++;
        end
        if (done) done_n++;
        if (err) err_n++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick(input logic [2:0] l);
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_burst(input int n);
        int w;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (!tx_dv && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!tx_dv) begin
                check("dv_wait", tx_dv, 1);
                return;
            end
            tx_ready = 1'b0; cs_n = 1'b0;
            @(negedge clk);
            rx_dv = 1'b1; rx_byte = slave_rx[b];
            @(negedge clk);
            rx_dv = 1'b0; tx_ready = 1'b1;
        end
        cs_n = 1'b1;
    endtask

    task automatic check_tx(input int base, input int n);
        #1;
        check("dv_count", dv_n - base, n);
        for (int i = 0; i < n; i++) check("tx_byte", dv_log[base + i], exp_tx[i]);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("done_drop", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int base, dn, en, n;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_dv", tx_dv, 0);
        check("rst_count", tx_count, 0);
        check("rst_rd", rd_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // three-byte burst
        wr(3'd0, 8'hA5); wr(3'd1, 8'h3C); wr(3'd2, 8'h0F);
        exp_tx[0] = 8'hA5; exp_tx[1] = 8'h3C; exp_tx[2] = 8'h0F;
        slave_rx[0] = 8'h5A; slave_rx[1] = 8'hC3; slave_rx[2] = 8'hF0;
        #1 base = dv_n;
        kick(3'd3);
        check("b3_busy", busy, 1);
        check("b3_count", tx_count, 3);
        run_burst(3);
        check("b3_count_held", tx_count, 3);
        check_tx(base, 3);
        wait_done();

        // full-length loopback burst
        wr(3'd3, 8'h4B);
        exp_tx[3] = 8'h4B;
        slave_rx[0] = 8'h11; slave_rx[1] = 8'h22; slave_rx[2] = 8'h33; slave_rx[3] = 8'h44;
        #1 base = dv_n;
        kick(3'd4);
        check("b4_count", tx_count, 4);
        run_burst(4);
        check_tx(base, 4);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            #1 check("rd_loop", rd_data, 8'h11 * (i + 1));
        end
        rd_addr = 3'd4;
        #1 check("rd_addr4", rd_data, 8'h00);
        rd_addr = 3'd7;
        #1 check("rd_addr7", rd_data, 8'h00);

        // illegal lengths
        @(negedge clk);
        base = dv_n;
        kick(3'd0);
        check("len0_err", err, 1);
        check("len0_busy", busy, 0);
        @(negedge clk);
        check("len0_err_drop", err, 0);
        kick(3'd5);
        check("len5_err", err, 1);
        check("len5_busy", busy, 0);
        @(negedge clk);
        check("len5_err_drop", err, 0);
        #1 check("bad_len_no_dv", dv_n - base, 0);

        // start and write during SEND are ignored
        @(negedge clk);
        base = dv_n;
        kick(3'd3);
        start = 1'b1; len = 3'd2; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("intr_count", tx_count, 3);
        run_burst(3);
        check_tx(base, 3);
        wait_done();
        #1 base = dv_n;
        kick(3'd1);
        check("len1_count", tx_count, 1);
        run_burst(1);
        check_tx(base, 1);
        wait_done();

        // reset after the second strobe of a four-byte burst
        rd_addr = 3'd0;
        #1 base = dv_n; dn = done_n; en = err_n;
        kick(3'd4);
        run_burst(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dv", tx_dv, 0);
        check("mid_rst_count", tx_count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rd", rd_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_tx(base, 2);
        check("abort_no_done", done_n - dn, 0);
        check("abort_no_err", err_n - en, 0);
        base = dv_n;
        exp_tx[0] = 8'h00;
        slave_rx[0] = 8'h77;
        kick(3'd1);
        run_burst(1);
        check_tx(base, 1);
        wait_done();
        rd_addr = 3'd0;
        #1 check("post_rst_rd0", rd_data, 8'h77);
        rd_addr = 3'd1;
        #1 check("post_rst_rd1", rd_data, 8'h00);

        // master never ready
        @(negedge clk);
        tx_ready = 1'b0;
        #1 base = dv_n; en = err_n;
`ifdef SPI_BURST_WATCHDOG_EN
        kick(3'd1);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wd_cycles", n, 20);
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        @(negedge clk);
        check("wd_err_drop", err, 0);
        #1 check("wd_no_dv", dv_n - base, 0);
        check("wd_no_done", done, 0);
`else
        kick(3'd1);
        repeat (40) @(negedge clk);
        check("hang_busy", busy, 1);
        #1 check("hang_no_err", err_n - en, 0);
        check("hang_no_dv", dv_n - base, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hang_recover", busy, 0);
`endif
        tx_ready = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
